// File: rtl/count_sequencer.sv
// Sequencer for the lab bit-counter: runs a WIDTH-bit count through a latched
// number of 0..limit passes with start/pause/abort. SEQ_DOWN_EN adds down-counting.
module count_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
`ifdef SEQ_DOWN_EN
  input  logic              down,
`endif
  input  logic [WIDTH-1:0]  limit,
  input  logic [PASS_W-1:0] passes,
  output logic [WIDTH-1:0]  count,
  output logic [PASS_W-1:0] pass_cnt,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  count_q;
  logic [WIDTH-1:0]  limit_q;
  logic [PASS_W-1:0] pass_cnt_q;
  logic [PASS_W-1:0] passes_q;
  logic              busy_q;
  logic              done_q;

  logic [PASS_W-1:0] pass_inc_d;
  logic [WIDTH-1:0]  count_step_d;
  logic [WIDTH-1:0]  count_reload_d;
  logic              terminal_d;
  logic              last_pass_d;

`ifdef SEQ_DOWN_EN
  logic down_q;

  always_comb begin
    terminal_d     = down_q ? (count_q == '0) : (count_q == limit_q);
    count_step_d   = down_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    count_reload_d = down_q ? limit_q : '0;
  end
`else
  always_comb begin
    terminal_d     = (count_q == limit_q);
    count_step_d   = count_q + WIDTH'(1);
    count_reload_d = '0;
  end
`endif

  // Pass increment wraps at PASS_W bits, which gives free-run its modulo behaviour.
  always_comb begin
    pass_inc_d  = pass_cnt_q + PASS_W'(1);
    last_pass_d = (passes_q != '0) && (pass_inc_d == passes_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pass_cnt_q <= '0;
      limit_q    <= '0;
      passes_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEQ_DOWN_EN
      down_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q    <= '0;
          pass_cnt_q <= '0;
          busy_q     <= 1'b0;
          if (start) begin
            limit_q  <= limit;
            passes_q <= passes;
            state_q  <= RUN;
            busy_q   <= 1'b1;
`ifdef SEQ_DOWN_EN
            down_q   <= down;
            count_q  <= down ? limit : '0;
`endif
          end
        end
        RUN: begin
          if (abort) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b0;
          end else if (pause) begin
            state_q <= HOLD;
          end else if (terminal_d) begin
            pass_cnt_q <= pass_inc_d;
            if (last_pass_d) begin
              state_q <= DONE;
              count_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              count_q <= count_reload_d;
            end
          end else begin
            count_q <= count_step_d;
          end
        end
        HOLD: begin
          if (abort) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b0;
          end else if (!pause) begin
            state_q <= RUN;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          count_q    <= '0;
          pass_cnt_q <= '0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          count_q    <= '0;
          pass_cnt_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign count    = count_q;
  assign pass_cnt = pass_cnt_q;
  assign state    = state_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
